uart_msg_seq: RTL and testbench

Message sequencer that sits directly upstream of `uart_tx` and drives its `uart_tx_en`/`uart_tx_data`/`uart_tx_busy` handshake. It holds a fixed ASCII message ("Hello World!\n") in an internal constant ROM and sends it one byte at a time, waiting for each frame to complete. After the last byte it idles for a programmable repeat delay, then sends the message again while `run` is high. In the top level it replaces the ad-hoc char-index/delay logic, with `run` tied to a `ui_in` bit.

---
 rtl/uart_msg_seq.sv | 115 +++++++++++
 tb/tb_uart_msg_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_seq.sv
// Byte sequencer feeding uart_tx: streams a fixed ASCII message from a constant ROM,
// then idles for a repeat delay. Define UART_MSG_SEQ_CRLF_EN for a CR+LF terminator.
module uart_msg_seq #(
    parameter int REPEAT_DELAY_CYCLES = 500000,
    parameter int DELAY_COUNTER_BITS  = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       msg_done,
    output logic       active
);

`ifdef UART_MSG_SEQ_CRLF_EN
    localparam logic [3:0] MSG_LAST = 4'd13;
`else
    localparam logic [3:0] MSG_LAST = 4'd12;
`endif

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_DELAY     = 3'd4;

    localparam bit SKIP_DELAY = (REPEAT_DELAY_CYCLES == 0);
    localparam logic [DELAY_COUNTER_BITS-1:0] DELAY_LOAD =
        SKIP_DELAY ? '0 : DELAY_COUNTER_BITS'(REPEAT_DELAY_CYCLES - 1);

    logic [2:0]                    state;
    logic [3:0]                    char_index;
    logic [DELAY_COUNTER_BITS-1:0] delay_cnt;

    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h65;
            4'd2:    b = 8'h6C;
            4'd3:    b = 8'h6C;
            4'd4:    b = 8'h6F;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h57;
            4'd7:    b = 8'h6F;
            4'd8:    b = 8'h72;
            4'd9:    b = 8'h6C;
            4'd10:   b = 8'h64;
            4'd11:   b = 8'h21;
`ifdef UART_MSG_SEQ_CRLF_EN
            4'd12:   b = 8'h0D;
            4'd13:   b = 8'h0A;
`else
            4'd12:   b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // The strobe is combinational so the byte is offered in the very cycle SEND sees
    // the transmitter free; it drops as soon as uart_tx raises busy.
    assign tx_en  = (state == ST_SEND) && !tx_busy;
    assign active = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            char_index <= '0;
            delay_cnt  <= '0;
            tx_data    <= 8'h00;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        tx_data    <= rom_byte(4'd0);
                        char_index <= '0;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (char_index == MSG_LAST) begin
                            msg_done   <= 1'b1;
                            char_index <= '0;
                            delay_cnt  <= DELAY_LOAD;
                            state      <= SKIP_DELAY ? ST_IDLE : ST_DELAY;
                        end else begin
                            char_index <= char_index + 4'd1;
                            tx_data    <= rom_byte(char_index + 4'd1);
                            state      <= ST_SEND;
                        end
                    end
                end
                ST_DELAY: begin
                    // run is deliberately ignored here so a dropped run never cuts the pause short.
                    if (delay_cnt == '0) state <= ST_IDLE;
                    else                 delay_cnt <= delay_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_seq.sv
// Randomized bench for uart_msg_seq against a behavioural uart_tx and a message-level
// reference (string contents, pulse counts, repeat-gap timing).
module tb_uart_msg_seq;
    localparam int RPT = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       msg_done;
    logic       active;

    logic       uart_busy;
    logic       hold_busy;
    int         uart_cnt;
    int         frame_len;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         msg_len;
    string      msg;

    logic [7:0] cap_q[$];
    int         cap_cyc_q[$];
    int         done_q[$];

    uart_msg_seq #(
        .REPEAT_DELAY_CYCLES(RPT),
        .DELAY_COUNTER_BITS (5)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .tx_busy (tx_busy),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .msg_done(msg_done),
        .active  (active)
    );

    always #5 clk = ~clk;

    assign tx_busy = uart_busy | hold_busy;

    // Behavioural uart_tx: busy from the edge after the strobe, for frame_len cycles.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_busy <= 1'b0;
            uart_cnt  <= 0;
        end else if (uart_busy) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_busy <= 1'b0;
        end else if (tx_en) begin
            uart_busy <= 1'b1;
            uart_cnt  <= frame_len;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (resetn) begin
            if (tx_en) begin
                cap_q.push_back(tx_data);
                cap_cyc_q.push_back(cyc);
            end
            if (msg_done) done_q.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_val(tag, cap_q.size() >= n, 1);
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_val(tag, done_q.size() >= n, 1);
    endtask

    task automatic check_msg(input string tag, input int base);
        for (int i = 0; i < msg_len; i++)
            if (base + i < cap_q.size())
                check_val($sformatf("%s_byte%0d", tag, i), cap_q[base + i], msg[i]);
    endtask

    task automatic clear_log();
        cap_q.delete();
        cap_cyc_q.delete();
        done_q.delete();
    endtask

    initial begin
`ifdef UART_MSG_SEQ_CRLF_EN
        msg = "Hello World!\r\n";
`else
        msg = "Hello World!\n";
`endif
        msg_len   = msg.len();
        resetn    = 1'b0;
        run       = 1'b1;
        hold_busy = 1'b0;
        frame_len = 20;

        repeat (3) @(negedge clk);
        check_val("rst_tx_en",    tx_en,    0);
        check_val("rst_tx_data",  tx_data,  0);
        check_val("rst_active",   active,   0);
        check_val("rst_msg_done", msg_done, 0);
        resetn = 1'b1;

        // Continuous run: full message, pause, then restart with 'H'.
        wait_bytes("msg1_restart_seen", msg_len + 1, 3000);
        check_val("msg1_done_count", done_q.size(), 1);
        check_msg("msg1", 0);
        if (done_q.size() >= 1 && cap_cyc_q.size() > msg_len) begin
            check_val("msg1_done_after_last", cap_cyc_q[msg_len - 1] < done_q[0], 1);
            check_val("repeat_gap", cap_cyc_q[msg_len] - done_q[0], RPT + 1);
            check_val("restart_byte", cap_q[msg_len], 8'h48);
        end

        // Drop run after the third byte of the second message.
        wait_bytes("msg2_third_byte", msg_len + 3, 200);
        @(posedge clk); #1 run = 1'b0;
        wait_done("msg2_done", 2, 3000);
        repeat (RPT + 3) @(negedge clk);
        check_val("msg2_parked_active", active, 0);
        check_val("msg2_byte_total", cap_q.size(), 2 * msg_len);
        check_msg("msg2", msg_len);
        repeat (40) @(negedge clk);
        check_val("parked_no_tx_en", cap_q.size(), 2 * msg_len);
        check_val("parked_done_count", done_q.size(), 2);

        // Busy held high while SEND waits.
        clear_log();
        frame_len = $urandom_range(2, 25);
        @(posedge clk); #1 hold_busy = 1'b1; run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        begin
            int hold_n = $urandom_range(3, 8);
            repeat (hold_n) begin
                @(negedge clk);
                check_val("hold_tx_en_low", tx_en, 0);
            end
        end
        check_val("hold_active", active, 1);
        @(posedge clk); #1 hold_busy = 1'b0;
        @(negedge clk);
        check_val("hold_release_en", tx_en, 1);
        check_val("hold_release_data", tx_data, 8'h48);
        @(negedge clk);
        check_val("hold_single_pulse", tx_en, 0);
        wait_done("hold_msg_done", 1, 800);
        check_val("hold_byte_total", cap_q.size(), msg_len);
        check_msg("hold", 0);
        repeat (RPT + 3) @(negedge clk);
        check_val("hold_parked", active, 0);

        // Asynchronous reset in the middle of the fifth byte's frame.
        clear_log();
        frame_len = $urandom_range(4, 25);
        @(posedge clk); #1 run = 1'b1;
        wait_bytes("rst_mid_byte5", 5, 800);
        repeat ($urandom_range(0, frame_len - 3)) @(posedge clk);
        @(posedge clk); #2 resetn = 1'b0;
        #1;
        check_val("midrst_tx_en",    tx_en,    0);
        check_val("midrst_tx_data",  tx_data,  0);
        check_val("midrst_active",   active,   0);
        check_val("midrst_msg_done", msg_done, 0);
        clear_log();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_done("midrst_msg_done_seen", 1, 1000);
        check_val("midrst_byte_total", cap_q.size(), msg_len);
        if (cap_q.size() > 0) check_val("midrst_first_byte", cap_q[0], 8'h48);
        check_msg("midrst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
